mul8_seq_ctrl: RTL and testbench
================================

// Module: mul8_seq_ctrl
// PURPOSE
// - Sequencer that time-shares one external combinational 4x4 array multiplier (8-bit product) to compute 8x8 unsigned products and optional running sums.
// - Each operation takes four nibble passes. Each partial product is shifted and summed into an ACC_W-bit accumulator.
// - Sits between the operand/command interface (valid/ready) and the shared 4x4 multiplier datapath.
// PARAMETERS
// - ACC_W  20  accumulator/result width; legal range 16..32; sums wrap modulo 2^ACC_W
// PORTS
// - clk        in   1      single clock, rising edge
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      operand pair offered
// - in_ready   out  1      controller can accept operands
// - in_a       in   8      multiplicand (unsigned)
// - in_b       in   8      multiplier (unsigned)
// - acc_mode   in   1      sampled at accept: 0 = acc starts at 0, 1 = add to existing acc
// - acc_clr    in   1      clear accumulator (IDLE only, see below)
// - mul_m      out  4      nibble to multiplier m port
// - mul_q      out  4      nibble to multiplier q port
// - mul_p      in   8      product from multiplier (combinational, same cycle)
// - busy       out  1      high in MUL state
// - out_valid  out  1      result available
// - out_ready  in   1      consumer takes result
// - result     out  ACC_W  accumulator value
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, acc=0, step=0, a/b regs=0.
//   - Resulting outputs: in_ready=1, busy=0, out_valid=0, result=0, mul_m=mul_q=0.
// - FSM states: IDLE, MUL, DONE. step is a 2-bit counter.
// - IDLE: in_ready=1.
//   - Accept = in_valid & in_ready at a rising edge.
//   - On accept: latch in_a/in_b; acc <= acc_mode ? acc : 0; step <= 0; go to MUL.
//   - Else if acc_clr: acc <= 0.
//   - acc_clr is ignored when it coincides with an accept. acc_mode alone decides in that case.
// - MUL: in_ready=0, busy=1.
//   - Nibble schedule, driven combinationally from latched a/b and step:
//     - step 0: mul_m=a[3:0], mul_q=b[3:0], shift 0
//     - step 1: mul_m=a[7:4], mul_q=b[3:0], shift 4
//     - step 2: mul_m=a[3:0], mul_q=b[7:4], shift 4
//     - step 3: mul_m=a[7:4], mul_q=b[7:4], shift 8
//   - Each MUL edge: acc <= (acc + (zero-extended mul_p << shift)) mod 2^ACC_W; step++.
//   - At step 3 the edge moves the FSM to DONE.
// - DONE: out_valid=1, result=acc. acc is held stable while out_ready=0.
//   - out_valid & out_ready at an edge: go to IDLE. Next operand can be accepted the following cycle.
// - mul_m/mul_q are 0 outside MUL. mul_p is ignored outside MUL.
// - result always equals acc, but is meaningful only while out_valid=1.
// - Latency:
//   - Accept at edge k.
//   - MUL occupies the cycles after edges k..k+3.
//   - out_valid rises after edge k+4.
//   - Minimum period is 6 cycles per operation (1 IDLE + 4 MUL + 1 DONE).
// - in_valid, acc_clr and acc_mode changes during MUL/DONE have no effect.
// - Reset asserted mid-MUL or mid-DONE aborts immediately. The partial result is discarded (acc=0).
// TESTING
// - Reset, then a=0x12, b=0x34, acc_mode=0 -> after 5 edges out_valid=1, result=0x003A8; mul_m/q sequence 2/4,1/4,2/3,1/3.
// - a=0xFF, b=0xFF, acc_mode=0, then same operands with acc_mode=1:
//   - ACC_W=20 -> results 0x0FE01 then 0x1FC02.
//   - ACC_W=16 -> results 0xFE01 then 0xFC02 (wrap).
// - Hold out_ready=0 for 10 cycles in DONE -> out_valid and result stable, in_ready=0, in_valid pulses ignored.
// - acc_clr=1 in IDLE with no in_valid, then a=0x01, b=0x01, acc_mode=1 -> result=0x00001.
// - Deassert rst_n during step 2 -> outputs immediately at reset values.
//   - Then a=0x0F, b=0x10, acc_mode=1 -> result=0x000F0.
// - Sweep all 65536 a/b pairs with acc_mode=0 and a behavioural 4x4 model on mul_p -> result == a*b every time.

Source files
------------

// File: rtl/mul8_seq_ctrl_if.sv
// Operand/command and result handshake bundle for the sequential 8x8 multiply controller.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface mul8_seq_ctrl_if #(
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             acc_mode;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;

  modport master (
    output in_valid, in_a, in_b, acc_mode, acc_clr, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, in_a, in_b, acc_mode, acc_clr, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// Time-shares one external 4x4 combinational multiplier to build 8x8 unsigned products
// in four nibble passes, optionally accumulating onto the previous result.
module mul8_seq_ctrl #(
  parameter int ACC_W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  mul8_seq_ctrl_if.slave      bus,
  output logic [3:0]          mul_m,
  output logic [3:0]          mul_q,
  input  logic [7:0]          mul_p,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] partial;
  logic             in_ready;
  logic             out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mul_m     = 4'd0;
    mul_q     = 4'd0;
    partial   = '0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        // An accept wins over acc_clr; acc_mode alone decides the starting value.
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          acc_d   = bus.acc_mode ? acc_q : '0;
          step_d  = 2'd0;
          state_d = MUL;
        end else if (bus.acc_clr) begin
          acc_d = '0;
        end
      end
      MUL: begin
        busy = 1'b1;
        unique case (step_q)
          2'd0: begin mul_m = a_q[3:0]; mul_q = b_q[3:0]; partial = ACC_W'(mul_p);       end
          2'd1: begin mul_m = a_q[7:4]; mul_q = b_q[3:0]; partial = ACC_W'(mul_p) << 4; end
          2'd2: begin mul_m = a_q[3:0]; mul_q = b_q[7:4]; partial = ACC_W'(mul_p) << 4; end
          default: begin mul_m = a_q[7:4]; mul_q = b_q[7:4]; partial = ACC_W'(mul_p) << 8; end
        endcase
        acc_d  = acc_q + partial;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = acc_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed bench for mul8_seq_ctrl: one ACC_W=20 and one ACC_W=16 instance driven in lockstep,
// each with its own behavioural 4x4 multiplier on mul_p.
module tb_mul8_seq_ctrl;

  logic clk;
  logic rst_n;

  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       acc_mode;
  logic       acc_clr;
  logic       out_ready;

  logic [3:0] mul_m20, mul_q20, mul_m16, mul_q16;
  logic [7:0] mul_p20, mul_p16;
  logic       busy20, busy16;
  logic [1:0] dbg20, dbg16;

  int n_assert = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];

  mul8_seq_ctrl_if #(.ACC_W(20)) bus20 ();
  mul8_seq_ctrl_if #(.ACC_W(16)) bus16 ();

  assign bus20.in_valid  = in_valid;
  assign bus20.in_a      = in_a;
  assign bus20.in_b      = in_b;
  assign bus20.acc_mode  = acc_mode;
  assign bus20.acc_clr   = acc_clr;
  assign bus20.out_ready = out_ready;
  assign bus16.in_valid  = in_valid;
  assign bus16.in_a      = in_a;
  assign bus16.in_b      = in_b;
  assign bus16.acc_mode  = acc_mode;
  assign bus16.acc_clr   = acc_clr;
  assign bus16.out_ready = out_ready;

  assign mul_p20 = {4'd0, mul_m20} * {4'd0, mul_q20};
  assign mul_p16 = {4'd0, mul_m16} * {4'd0, mul_q16};

  mul8_seq_ctrl #(.ACC_W(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .bus(bus20.slave),
    .mul_m(mul_m20), .mul_q(mul_q20), .mul_p(mul_p20),
    .busy(busy20), .dbg_state(dbg20)
  );

  mul8_seq_ctrl #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave),
    .mul_m(mul_m16), .mul_q(mul_q16), .mul_p(mul_p16),
    .busy(busy16), .dbg_state(dbg16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  32'(bus20.in_ready),  32'd1);
    chk({tag, ".busy"},      32'(busy20),          32'd0);
    chk({tag, ".out_valid"}, 32'(bus20.out_valid), 32'd0);
    chk({tag, ".result20"},  32'(bus20.result),    32'd0);
    chk({tag, ".result16"},  32'(bus16.result),    32'd0);
    chk({tag, ".mul_m"},     32'(mul_m20),         32'd0);
    chk({tag, ".mul_q"},     32'(mul_q20),         32'd0);
    chk({tag, ".state"},     32'(dbg20),           32'd0);
  endtask

  // One operation: offer, check nibble schedule, optionally stall in DONE, then take result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic mode, input logic [19:0] exp20, input logic [15:0] exp16,
                        input int hold);
    logic [3:0]  em [4];
    logic [3:0]  eq [4];
    logic [19:0] want;
    em[0] = a[3:0]; eq[0] = b[3:0];
    em[1] = a[7:4]; eq[1] = b[3:0];
    em[2] = a[3:0]; eq[2] = b[7:4];
    em[3] = a[7:4]; eq[3] = b[7:4];
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 32'(bus20.in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; acc_mode = mode;
    exp_q.push_back(exp20);
    @(negedge clk);
    in_valid = 1'b0; acc_mode = ~mode; in_a = 8'h00; in_b = 8'h00;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("%s.busy%0d", tag, s),  32'(busy20),  32'd1);
      chk($sformatf("%s.m%0d", tag, s),     32'(mul_m20), 32'(em[s]));
      chk($sformatf("%s.q%0d", tag, s),     32'(mul_q20), 32'(eq[s]));
      chk($sformatf("%s.rdy%0d", tag, s),   32'(bus20.in_ready), 32'd0);
      @(negedge clk);
    end
    want = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("%s.hold_ov%0d", tag, h),  32'(bus20.out_valid), 32'd1);
      chk($sformatf("%s.hold_res%0d", tag, h), 32'(bus20.result),    32'(want));
      chk($sformatf("%s.hold_rdy%0d", tag, h), 32'(bus20.in_ready),  32'd0);
      in_valid = h[0]; in_a = 8'hA5; in_b = 8'h5A; acc_clr = h[1];
      @(negedge clk);
    end
    in_valid = 1'b0; acc_clr = 1'b0;
    chk({tag, ".out_valid"}, 32'(bus20.out_valid), 32'd1);
    chk({tag, ".busy_done"}, 32'(busy20),          32'd0);
    chk({tag, ".result20"},  32'(bus20.result),    32'(want));
    chk({tag, ".result16"},  32'(bus16.result),    32'(exp16));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".ov_after"},  32'(bus20.out_valid), 32'd0);
    chk({tag, ".rdy_after"}, 32'(bus20.in_ready),  32'd1);
  endtask

  initial begin
    logic [7:0] vals [8];
    logic [15:0] p;
    vals[0] = 8'h00; vals[1] = 8'h01; vals[2] = 8'h0F; vals[3] = 8'h10;
    vals[4] = 8'h7F; vals[5] = 8'h80; vals[6] = 8'hF0; vals[7] = 8'hFF;

    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    run_op("basic", 8'h12, 8'h34, 1'b0, 20'h003A8, 16'h03A8, 0);
    run_op("ff0",   8'hFF, 8'hFF, 1'b0, 20'h0FE01, 16'hFE01, 0);
    run_op("ff1",   8'hFF, 8'hFF, 1'b1, 20'h1FC02, 16'hFC02, 0);
    run_op("hold",  8'h21, 8'h03, 1'b0, 20'h00063, 16'h0063, 10);

    // acc_clr in IDLE, then accumulate onto the cleared value.
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("clr.result20", 32'(bus20.result), 32'd0);
    run_op("clr", 8'h01, 8'h01, 1'b1, 20'h00001, 16'h0001, 0);

    // acc_clr coinciding with accept is ignored: acc_mode=1 keeps the 1 from above.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h02; in_b = 8'h03; acc_mode = 1'b1; acc_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; acc_clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("clr_acc.ov",     32'(bus20.out_valid), 32'd1);
    chk("clr_acc.result", 32'(bus20.result),    32'h00007);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of step 2 aborts at once.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hC3; in_b = 8'h9A; acc_mode = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.step2_m", 32'(mul_m20), 32'h3);
    chk("mid.step2_q", 32'(mul_q20), 32'h9);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post", 8'h0F, 8'h10, 1'b1, 20'h000F0, 16'h00F0, 0);

    // Corner-value sweep, fresh accumulator every time.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        p = 16'(vals[i]) * 16'(vals[j]);
        run_op($sformatf("sw_%0h_%0h", vals[i], vals[j]), vals[i], vals[j], 1'b0,
               20'(p), p, 0);
      end
    end

    chk("exp_q.empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
